// File: rtl/pipe_controller.sv
// Pipelined MIPS control: ID decode, ID/EX, EX/MEM and MEM/WB control registers, hazard stall/flush.
// Define PIPE_CTRL_FWD_EN to generate EX forwarding selects (load-use is then the only stall source).
module pipe_controller #(
    parameter int REG_AW   = 5,
    parameter int ALUCTR_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr_id,
    input  logic                branch_taken_ex,
    output logic                stall,
    output logic                flush_ifid,
    output logic [1:0]          id_ExtOp,
    output logic                id_j_sel,
    output logic                id_illegal,
    output logic                ex_RegDst,
    output logic                ex_ALUSrc,
    output logic [ALUCTR_W-1:0] ex_ALUctr,
    output logic                ex_nPC_sel,
    output logic                ex_bne,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic                mem_MemWr,
    output logic                wb_RegWr,
    output logic                wb_MemtoReg,
    output logic [REG_AW-1:0]   wb_waddr
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_LUI  = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;

    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;

    // One stage worth of control; an all-zero value is a bubble.
    typedef struct packed {
        logic                reg_dst;
        logic                alu_src;
        logic [ALUCTR_W-1:0] alu_ctr;
        logic                npc_sel;
        logic                bne;
        logic                mem_wr;
        logic                reg_wr;
        logic                mem_to_reg;
        logic                is_lw;
        logic [REG_AW-1:0]   rs;
        logic [REG_AW-1:0]   rt;
        logic [REG_AW-1:0]   waddr;
        logic                rs_used;
        logic                rt_used;
    } ctrl_t;

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [REG_AW-1:0] f_rs;
    logic [REG_AW-1:0] f_rt;
    logic [REG_AW-1:0] f_rd;

    assign op    = instr_id[31:26];
    assign funct = instr_id[5:0];
    assign f_rs  = REG_AW'(instr_id[25:21]);
    assign f_rt  = REG_AW'(instr_id[20:16]);
    assign f_rd  = REG_AW'(instr_id[15:11]);

    ctrl_t      dec_id;
    logic [1:0] ext_op_c;
    logic       j_sel_c;
    logic       illegal_c;

    always_comb begin
        dec_id    = '0;
        ext_op_c  = EXT_ZERO;
        j_sel_c   = 1'b0;
        illegal_c = 1'b0;
        case (op)
            OP_RTYPE: begin
                if (instr_id != 32'd0) begin
                    dec_id.reg_dst = 1'b1;
                    dec_id.reg_wr  = 1'b1;
                    dec_id.waddr   = f_rd;
                    dec_id.rs      = f_rs;
                    dec_id.rt      = f_rt;
                    dec_id.rs_used = 1'b1;
                    dec_id.rt_used = 1'b1;
                    case (funct)
                        FN_ADDU: dec_id.alu_ctr = ALUCTR_W'(ALU_ADD);
                        FN_SUBU: dec_id.alu_ctr = ALUCTR_W'(ALU_SUB);
                        FN_AND:  dec_id.alu_ctr = ALUCTR_W'(ALU_AND);
                        FN_OR:   dec_id.alu_ctr = ALUCTR_W'(ALU_OR);
                        FN_SLT:  dec_id.alu_ctr = ALUCTR_W'(ALU_SLT);
                        default: begin
                            dec_id    = '0;
                            illegal_c = 1'b1;
                        end
                    endcase
                end
            end
            OP_ORI: begin
                ext_op_c       = EXT_ZERO;
                dec_id.alu_src = 1'b1;
                dec_id.alu_ctr = ALUCTR_W'(ALU_OR);
                dec_id.reg_wr  = 1'b1;
                dec_id.waddr   = f_rt;
                dec_id.rs      = f_rs;
                dec_id.rs_used = 1'b1;
            end
            OP_ADDIU: begin
                ext_op_c       = EXT_SIGN;
                dec_id.alu_src = 1'b1;
                dec_id.alu_ctr = ALUCTR_W'(ALU_ADD);
                dec_id.reg_wr  = 1'b1;
                dec_id.waddr   = f_rt;
                dec_id.rs      = f_rs;
                dec_id.rs_used = 1'b1;
            end
            OP_LW: begin
                ext_op_c          = EXT_SIGN;
                dec_id.alu_src    = 1'b1;
                dec_id.alu_ctr    = ALUCTR_W'(ALU_ADD);
                dec_id.reg_wr     = 1'b1;
                dec_id.mem_to_reg = 1'b1;
                dec_id.is_lw      = 1'b1;
                dec_id.waddr      = f_rt;
                dec_id.rs         = f_rs;
                dec_id.rs_used    = 1'b1;
            end
            OP_SW: begin
                ext_op_c       = EXT_SIGN;
                dec_id.alu_src = 1'b1;
                dec_id.alu_ctr = ALUCTR_W'(ALU_ADD);
                dec_id.mem_wr  = 1'b1;
                dec_id.rs      = f_rs;
                dec_id.rt      = f_rt;
                dec_id.rs_used = 1'b1;
                dec_id.rt_used = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ext_op_c       = EXT_SIGN;
                dec_id.alu_ctr = ALUCTR_W'(ALU_SUB);
                dec_id.npc_sel = 1'b1;
                dec_id.bne     = (op == OP_BNE);
                dec_id.rs      = f_rs;
                dec_id.rt      = f_rt;
                dec_id.rs_used = 1'b1;
                dec_id.rt_used = 1'b1;
            end
            OP_LUI: begin
                ext_op_c       = EXT_UPPER;
                dec_id.alu_src = 1'b1;
                dec_id.alu_ctr = ALUCTR_W'(ALU_LUI);
                dec_id.reg_wr  = 1'b1;
                dec_id.waddr   = f_rt;
            end
            OP_J: begin
                ext_op_c       = EXT_SIGN;
                dec_id.alu_ctr = ALUCTR_W'(ALU_ADD);
                j_sel_c        = 1'b1;
            end
            default: begin
                illegal_c = 1'b1;
            end
        endcase
    end

    // A stage blocks a source only if it really writes a nonzero register.
    function automatic logic dest_hit(input ctrl_t s, input logic [REG_AW-1:0] src,
                                      input logic used);
        return used && s.reg_wr && (s.waddr != '0) && (s.waddr == src);
    endfunction

    ctrl_t idex_d, idex_q;
    ctrl_t exmem_d, exmem_q;
    ctrl_t memwb_d, memwb_q;

    logic ex_hit;
    logic hazard;
    logic br_taken;
    logic stall_c;
    logic flush_c;
    logic [1:0] fwd_a_c;
    logic [1:0] fwd_b_c;

    assign ex_hit = dest_hit(idex_q, dec_id.rs, dec_id.rs_used)
                 || dest_hit(idex_q, dec_id.rt, dec_id.rt_used);

`ifdef PIPE_CTRL_FWD_EN
    assign hazard = idex_q.is_lw && ex_hit;

    always_comb begin
        fwd_a_c = 2'b00;
        fwd_b_c = 2'b00;
        if (dest_hit(exmem_q, idex_q.rs, idex_q.rs_used)) begin
            fwd_a_c = 2'b10;
        end else if (dest_hit(memwb_q, idex_q.rs, idex_q.rs_used)) begin
            fwd_a_c = 2'b01;
        end
        if (dest_hit(exmem_q, idex_q.rt, idex_q.rt_used)) begin
            fwd_b_c = 2'b10;
        end else if (dest_hit(memwb_q, idex_q.rt, idex_q.rt_used)) begin
            fwd_b_c = 2'b01;
        end
    end
`else
    logic mem_hit;

    assign mem_hit = dest_hit(exmem_q, dec_id.rs, dec_id.rs_used)
                  || dest_hit(exmem_q, dec_id.rt, dec_id.rt_used);
    assign hazard  = ex_hit || mem_hit;
    assign fwd_a_c = 2'b00;
    assign fwd_b_c = 2'b00;
`endif

    // A taken branch kills the ID instruction, so its hazard must not stall.
    assign br_taken = idex_q.npc_sel && (branch_taken_ex ^ idex_q.bne);
    assign flush_c  = !rst && (br_taken || j_sel_c);
    assign stall_c  = !rst && hazard && !br_taken;

    always_comb begin
        idex_d  = dec_id;
        if (br_taken || stall_c) begin
            idex_d = '0;
        end
        exmem_d = idex_q;
        memwb_d = exmem_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign stall       = stall_c;
    assign flush_ifid  = flush_c;
    assign id_ExtOp    = ext_op_c;
    assign id_j_sel    = j_sel_c;
    assign id_illegal  = illegal_c;

    assign ex_RegDst   = idex_q.reg_dst;
    assign ex_ALUSrc   = idex_q.alu_src;
    assign ex_ALUctr   = idex_q.alu_ctr;
    assign ex_nPC_sel  = idex_q.npc_sel;
    assign ex_bne      = idex_q.bne;
    assign fwd_a       = fwd_a_c;
    assign fwd_b       = fwd_b_c;

    assign mem_MemWr   = exmem_q.mem_wr;

    assign wb_RegWr    = memwb_q.reg_wr;
    assign wb_MemtoReg = memwb_q.mem_to_reg;
    assign wb_waddr    = memwb_q.waddr;

    // Last-stage fields and the shamt field have no consumer here.
    logic unused_bits;
    assign unused_bits = ^{memwb_q, instr_id[10:6]};

endmodule

// File: tb/tb_pipe_controller.sv
// Scoreboard bench for pipe_controller: driver queues expected outputs per cycle, a negedge monitor compares.
module tb_pipe_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_id;
    logic        branch_taken_ex;
    logic        stall, flush_ifid, id_j_sel, id_illegal;
    logic [1:0]  id_ExtOp;
    logic        ex_RegDst, ex_ALUSrc, ex_nPC_sel, ex_bne;
    logic [2:0]  ex_ALUctr;
    logic [1:0]  fwd_a, fwd_b;
    logic        mem_MemWr, wb_RegWr, wb_MemtoReg;
    logic [4:0]  wb_waddr;

    pipe_controller #(.REG_AW(5), .ALUCTR_W(3)) dut (
        .clk(clk), .rst(rst), .instr_id(instr_id), .branch_taken_ex(branch_taken_ex),
        .stall(stall), .flush_ifid(flush_ifid), .id_ExtOp(id_ExtOp), .id_j_sel(id_j_sel),
        .id_illegal(id_illegal), .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc),
        .ex_ALUctr(ex_ALUctr), .ex_nPC_sel(ex_nPC_sel), .ex_bne(ex_bne),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_MemWr(mem_MemWr), .wb_RegWr(wb_RegWr),
        .wb_MemtoReg(wb_MemtoReg), .wb_waddr(wb_waddr)
    );

    always #5 clk = ~clk;

    localparam int S_STALL = 0, S_FLUSH = 1, S_EXTOP = 2, S_JSEL = 3, S_ILL = 4,
                   S_REGDST = 5, S_ALUSRC = 6, S_ALUCTR = 7, S_NPC = 8, S_BNE = 9,
                   S_FWDA = 10, S_FWDB = 11, S_MEMWR = 12, S_REGWR = 13, S_MEMTOREG = 14,
                   S_WADDR = 15;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sig_name(input int s);
        case (s)
            S_STALL:    return "stall";
            S_FLUSH:    return "flush_ifid";
            S_EXTOP:    return "id_ExtOp";
            S_JSEL:     return "id_j_sel";
            S_ILL:      return "id_illegal";
            S_REGDST:   return "ex_RegDst";
            S_ALUSRC:   return "ex_ALUSrc";
            S_ALUCTR:   return "ex_ALUctr";
            S_NPC:      return "ex_nPC_sel";
            S_BNE:      return "ex_bne";
            S_FWDA:     return "fwd_a";
            S_FWDB:     return "fwd_b";
            S_MEMWR:    return "mem_MemWr";
            S_REGWR:    return "wb_RegWr";
            S_MEMTOREG: return "wb_MemtoReg";
            default:    return "wb_waddr";
        endcase
    endfunction

    function automatic logic [31:0] peek(input int s);
        case (s)
            S_STALL:    return 32'(stall);
            S_FLUSH:    return 32'(flush_ifid);
            S_EXTOP:    return 32'(id_ExtOp);
            S_JSEL:     return 32'(id_j_sel);
            S_ILL:      return 32'(id_illegal);
            S_REGDST:   return 32'(ex_RegDst);
            S_ALUSRC:   return 32'(ex_ALUSrc);
            S_ALUCTR:   return 32'(ex_ALUctr);
            S_NPC:      return 32'(ex_nPC_sel);
            S_BNE:      return 32'(ex_bne);
            S_FWDA:     return 32'(fwd_a);
            S_FWDB:     return 32'(fwd_b);
            S_MEMWR:    return 32'(mem_MemWr);
            S_REGWR:    return 32'(wb_RegWr);
            S_MEMTOREG: return 32'(wb_MemtoReg);
            default:    return 32'(wb_waddr);
        endcase
    endfunction

    // Monitor: every entry due this cycle is compared and retired.
    always @(negedge clk) begin
        logic [31:0] got;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                got = peek(sb[i].sig);
                checks++;
                if (got !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%0h exp=%0h", sig_name(sb[i].sig), cyc,
                             got, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input int rs, input int rt,
                                          input int rd);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    task automatic ck(input int dc, input int sig, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc + dc;
        e.sig = sig;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [31:0] ins, input logic bt);
        instr_id        = ins;
        branch_taken_ex = bt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drive(32'd0, 1'b0);
        repeat (3) tick();
    endtask

    typedef struct {
        logic [31:0] ins;
        int ext, src, ctr, rdst, rw, mw, m2r, wa;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // rst held over two edges with addu in ID
        rst = 1'b1;
        drive(r_ins(6'b100001, 1, 2, 3), 1'b0);
        tick();
        ck(0, S_STALL, 0); ck(0, S_FLUSH, 0); ck(0, S_REGDST, 0); ck(0, S_ALUCTR, 0);
        tick();
        ck(0, S_STALL, 0); ck(0, S_FLUSH, 0); ck(0, S_REGDST, 0); ck(0, S_ALUSRC, 0);
        ck(0, S_MEMWR, 0); ck(0, S_REGWR, 0); ck(0, S_MEMTOREG, 0); ck(0, S_WADDR, 0);
        ck(0, S_FWDA, 0); ck(0, S_FWDB, 0); ck(0, S_NPC, 0); ck(0, S_BNE, 0);
        rst = 1'b0;
        drive(32'd0, 1'b0);
        tick();

        // RAW: addu $3,$1,$2 then subu $4,$3,$1 then or $5,$3,$0
        drive(r_ins(6'b100001, 1, 2, 3), 1'b0);
        ck(0, S_STALL, 0); ck(1, S_REGDST, 1); ck(1, S_ALUSRC, 0); ck(1, S_ALUCTR, 0);
        ck(2, S_MEMWR, 0); ck(3, S_REGWR, 1); ck(3, S_WADDR, 3); ck(3, S_MEMTOREG, 0);
        tick();
        drive(r_ins(6'b100011, 3, 1, 4), 1'b0);
`ifdef PIPE_CTRL_FWD_EN
        ck(0, S_STALL, 0); ck(1, S_ALUCTR, 1); ck(1, S_FWDA, 2); ck(1, S_FWDB, 0);
        tick();
        drive(r_ins(6'b100101, 3, 0, 5), 1'b0);
        ck(0, S_STALL, 0); ck(1, S_ALUCTR, 2); ck(1, S_FWDA, 1); ck(1, S_FWDB, 0);
        tick();
`else
        ck(0, S_STALL, 1); ck(0, S_FWDA, 0); ck(1, S_REGDST, 0); ck(1, S_ALUCTR, 0);
        tick();
        ck(0, S_STALL, 1); ck(0, S_FWDA, 0); ck(1, S_REGDST, 0);
        tick();
        ck(0, S_STALL, 0); ck(1, S_ALUCTR, 1); ck(1, S_REGDST, 1); ck(1, S_FWDA, 0);
        tick();
        drive(r_ins(6'b100101, 3, 0, 5), 1'b0);
        ck(0, S_STALL, 0); ck(1, S_ALUCTR, 2); ck(1, S_FWDA, 0);
        tick();
`endif
        drain();

        // Load-use: lw $5,0($1) then addu $6,$2,$5
        drive(i_ins(6'b100011, 1, 5, 16'h0000), 1'b0);
        ck(0, S_STALL, 0); ck(0, S_EXTOP, 1); ck(1, S_ALUSRC, 1); ck(1, S_ALUCTR, 0);
        ck(1, S_REGDST, 0); ck(2, S_MEMWR, 0); ck(3, S_REGWR, 1); ck(3, S_MEMTOREG, 1);
        ck(3, S_WADDR, 5);
        tick();
        drive(r_ins(6'b100001, 2, 5, 6), 1'b0);
        ck(0, S_STALL, 1); ck(0, S_FLUSH, 0); ck(1, S_REGDST, 0); ck(1, S_ALUSRC, 0);
        ck(1, S_ALUCTR, 0); ck(1, S_NPC, 0);
        tick();
`ifdef PIPE_CTRL_FWD_EN
        ck(0, S_STALL, 0); ck(1, S_REGDST, 1); ck(1, S_FWDB, 1); ck(1, S_FWDA, 0);
        tick();
`else
        ck(0, S_STALL, 1); ck(1, S_REGDST, 0);
        tick();
        ck(0, S_STALL, 0); ck(1, S_REGDST, 1); ck(1, S_FWDB, 0);
        tick();
`endif
        drain();

        // Taken bne in EX beats a pending hazard on $9
        drive(i_ins(6'b100011, 1, 9, 16'h0000), 1'b0);
        tick();
        drive(i_ins(6'b000101, 7, 8, 16'h0004), 1'b0);
        ck(0, S_STALL, 0); ck(0, S_EXTOP, 1);
        tick();
        drive(r_ins(6'b100001, 9, 9, 10), 1'b0);
        ck(0, S_FLUSH, 1); ck(0, S_STALL, 0); ck(0, S_NPC, 1); ck(0, S_BNE, 1);
        ck(0, S_ALUCTR, 1); ck(1, S_NPC, 0); ck(1, S_REGDST, 0); ck(1, S_ALUCTR, 0);
        ck(1, S_BNE, 0);
        tick();
        drive(32'd0, 1'b0);
        ck(0, S_FLUSH, 0);
        tick();

        // beq taken, then bne with equal operands (not taken)
        drive(i_ins(6'b000100, 1, 2, 16'h0008), 1'b0);
        tick();
        drive(32'd0, 1'b1);
        ck(0, S_FLUSH, 1); ck(0, S_NPC, 1); ck(0, S_BNE, 0); ck(1, S_NPC, 0);
        tick();
        drive(i_ins(6'b000101, 1, 2, 16'h0008), 1'b0);
        ck(0, S_FLUSH, 0);
        tick();
        drive(32'd0, 1'b1);
        ck(0, S_FLUSH, 0); ck(0, S_NPC, 1); ck(0, S_BNE, 1);
        tick();
        drain();

        // Jump, illegal opcode, illegal funct, nop
        drive({6'b000010, 26'h0000100}, 1'b0);
        ck(0, S_JSEL, 1); ck(0, S_FLUSH, 1); ck(0, S_EXTOP, 1); ck(0, S_STALL, 0);
        ck(0, S_ILL, 0); ck(1, S_ALUCTR, 0); ck(1, S_REGDST, 0);
        tick();
        drive(i_ins(6'b111111, 1, 5, 16'h0000), 1'b0);
        ck(0, S_ILL, 1); ck(0, S_JSEL, 0); ck(0, S_FLUSH, 0); ck(0, S_EXTOP, 0);
        ck(1, S_ALUSRC, 0); ck(3, S_REGWR, 0); ck(3, S_WADDR, 0);
        tick();
        drive(r_ins(6'b000000, 1, 2, 7), 1'b0);
        ck(0, S_ILL, 1); ck(1, S_REGDST, 0); ck(3, S_REGWR, 0);
        tick();
        drive(32'd0, 1'b0);
        ck(0, S_ILL, 0); ck(0, S_JSEL, 0); ck(3, S_REGWR, 0);
        tick();

        // Decode table, back-to-back independent instructions
        vecs.push_back('{r_ins(6'b100100, 12, 13, 11), 0, 0, 4, 1, 1, 0, 0, 11});
        vecs.push_back('{r_ins(6'b100101, 1, 2, 14),   0, 0, 2, 1, 1, 0, 0, 14});
        vecs.push_back('{r_ins(6'b101010, 1, 2, 15),   0, 0, 5, 1, 1, 0, 0, 15});
        vecs.push_back('{i_ins(6'b001101, 1, 16, 16'h00ff), 0, 1, 2, 0, 1, 0, 0, 16});
        vecs.push_back('{i_ins(6'b001001, 1, 17, 16'hfffc), 1, 1, 0, 0, 1, 0, 0, 17});
        vecs.push_back('{i_ins(6'b001111, 0, 18, 16'h1234), 2, 1, 3, 0, 1, 0, 0, 18});
        vecs.push_back('{i_ins(6'b101011, 1, 19, 16'h0008), 1, 1, 0, 0, 0, 1, 0, 0});
        vecs.push_back('{r_ins(6'b100011, 1, 2, 20),   0, 0, 1, 1, 1, 0, 0, 20});
        foreach (vecs[i]) begin
            drive(vecs[i].ins, 1'b0);
            ck(0, S_EXTOP, vecs[i].ext); ck(0, S_ILL, 0); ck(0, S_STALL, 0);
            ck(1, S_ALUSRC, vecs[i].src); ck(1, S_ALUCTR, vecs[i].ctr);
            ck(1, S_REGDST, vecs[i].rdst); ck(2, S_MEMWR, vecs[i].mw);
            ck(3, S_REGWR, vecs[i].rw); ck(3, S_MEMTOREG, vecs[i].m2r);
            ck(3, S_WADDR, vecs[i].wa);
            tick();
        end
        drain();

        // Reset during a load-use stall
        drive(i_ins(6'b100011, 1, 5, 16'h0000), 1'b0);
        tick();
        drive(r_ins(6'b100001, 2, 5, 6), 1'b0);
        ck(0, S_STALL, 1);
        tick();
        rst = 1'b1;
        ck(0, S_STALL, 0); ck(0, S_FLUSH, 0);
        tick();
        rst = 1'b0;
        ck(0, S_STALL, 0); ck(0, S_REGDST, 0); ck(0, S_REGWR, 0); ck(0, S_MEMWR, 0);
        ck(1, S_REGDST, 1); ck(1, S_ALUCTR, 0);
        tick();
        drain();

        repeat (2) tick();
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
            errors += sb.size();
            checks += sb.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
